eqed_sig_checker: RTL and testbench

//  Reads back the MISR signatures that the E-QED harness compacts: arms on a start pulse, confirms every MISR holds its seed,

---
 rtl/eqed_sig_checker.sv | 133 +++++++++++++
 tb/tb_eqed_sig_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eqed_sig_checker.sv
// E-QED signature checker: arms on start, verifies MISR seeds, waits a programmable
// window, then compares the captured MISR signatures and keeps saturating pass/fail tallies.
module eqed_sig_checker #(
  parameter int SIG_W = 6,
  parameter int WIN_W = 10,
  parameter logic [SIG_W-1:0] SEED = {{(SIG_W-1){1'b0}}, 1'b1},
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [SIG_W-1:0] out_sig_1,
  input  logic [SIG_W-1:0] out_sig_2,
  input  logic [SIG_W-1:0] exp_in,
  input  logic [SIG_W-1:0] exp_out_1,
  input  logic [SIG_W-1:0] exp_out_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       mismatch_mask,
  output logic [SIG_W-1:0] cap_in,
  output logic [SIG_W-1:0] cap_out_1,
  output logic [SIG_W-1:0] cap_out_2,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  state_t           state;
  logic [WIN_W-1:0] cnt;
  logic [SIG_W-1:0] exp_in_q, exp_out_1_q, exp_out_2_q;
  logic             seed_err_q;

  logic             accept;
  logic             seed_err_now;
  logic             compare_now;
  logic [SIG_W-1:0] cmp_in, cmp_out_1, cmp_out_2;
  logic [3:0]       mask_now;

  // Start acceptance, seed check and the final compare vector. A zero-length window
  // compares against the expected values arriving with start in that same cycle.
  always_comb begin
    accept       = start && ((state == IDLE) || (state == DONE));
    seed_err_now = (in_sig != SEED) || (out_sig_1 != SEED) || (out_sig_2 != SEED);
    compare_now  = (accept && (window_len == '0)) || (state == CHECK);
    if (accept) begin
      cmp_in    = exp_in;
      cmp_out_1 = exp_out_1;
      cmp_out_2 = exp_out_2;
      mask_now[3] = seed_err_now;
    end else begin
      cmp_in    = exp_in_q;
      cmp_out_1 = exp_out_1_q;
      cmp_out_2 = exp_out_2_q;
      mask_now[3] = seed_err_q;
    end
    mask_now[0] = (in_sig != cmp_in);
    mask_now[1] = (out_sig_1 != cmp_out_1);
    mask_now[2] = (out_sig_2 != cmp_out_2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      exp_in_q      <= '0;
      exp_out_1_q   <= '0;
      exp_out_2_q   <= '0;
      seed_err_q    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_mask <= 4'b0000;
      cap_in        <= '0;
      cap_out_1     <= '0;
      cap_out_2     <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        exp_in_q      <= exp_in;
        exp_out_1_q   <= exp_out_1;
        exp_out_2_q   <= exp_out_2;
        seed_err_q    <= seed_err_now;
        pass          <= 1'b0;
        mismatch_mask <= 4'b0000;
        cnt           <= window_len;
        if (window_len == '0) begin
          state <= DONE;
          busy  <= 1'b0;
        end else if (window_len == WIN_W'(1)) begin
          state <= CHECK;
          busy  <= 1'b1;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          // RUN covers window cycles 1..len-1; CHECK is the last window cycle.
          RUN: begin
            cnt <= cnt - 1'b1;
            if (cnt == WIN_W'(2)) state <= CHECK;
          end
          CHECK: begin
            state <= DONE;
            busy  <= 1'b0;
          end
          default: state <= state;
        endcase
      end

      if (compare_now) begin
        mismatch_mask <= mask_now;
        pass          <= ~|mask_now;
        cap_in        <= in_sig;
        cap_out_1     <= out_sig_1;
        cap_out_2     <= out_sig_2;
        done          <= 1'b1;
        if (~|mask_now) begin
          if (pass_count != {CNT_W{1'b1}}) pass_count <= pass_count + 1'b1;
        end else begin
          if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eqed_sig_checker.sv
// Directed bench for eqed_sig_checker; a second instance with 2-bit tallies checks saturation.
module tb_eqed_sig_checker;

  logic       clk = 1'b0;
  logic       rst, rst2, start;
  logic [9:0] window_len;
  logic [5:0] in_sig, out_sig_1, out_sig_2, exp_in, exp_out_1, exp_out_2;
  logic       busy, done, pass;
  logic [3:0] mismatch_mask;
  logic [5:0] cap_in, cap_out_1, cap_out_2;
  logic [7:0] pass_count, fail_count;
  logic       busy2, done2, pass2;
  logic [3:0] mask2;
  logic [5:0] cap_in2, cap_out_12, cap_out_22;
  logic [1:0] pass_count2, fail_count2;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  eqed_sig_checker dut (
    .clk(clk), .rst(rst), .start(start), .window_len(window_len),
    .in_sig(in_sig), .out_sig_1(out_sig_1), .out_sig_2(out_sig_2),
    .exp_in(exp_in), .exp_out_1(exp_out_1), .exp_out_2(exp_out_2),
    .busy(busy), .done(done), .pass(pass), .mismatch_mask(mismatch_mask),
    .cap_in(cap_in), .cap_out_1(cap_out_1), .cap_out_2(cap_out_2),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  eqed_sig_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start), .window_len(window_len),
    .in_sig(in_sig), .out_sig_1(out_sig_1), .out_sig_2(out_sig_2),
    .exp_in(exp_in), .exp_out_1(exp_out_1), .exp_out_2(exp_out_2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_mask(mask2),
    .cap_in(cap_in2), .cap_out_1(cap_out_12), .cap_out_2(cap_out_22),
    .pass_count(pass_count2), .fail_count(fail_count2)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sigs(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    in_sig = a; out_sig_1 = b; out_sig_2 = c;
  endtask

  // Drive a start in the current cycle T and advance into T+1.
  task automatic pulse_start(input logic [9:0] wl, input logic [5:0] ea,
                             input logic [5:0] eb, input logic [5:0] ec);
    start = 1'b1; window_len = wl; exp_in = ea; exp_out_1 = eb; exp_out_2 = ec;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; window_len = 10'd0;
    set_sigs(6'd1, 6'd1, 6'd1);
    exp_in = 6'd0; exp_out_1 = 6'd0; exp_out_2 = 6'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
    vectors++;
    if ({busy, done, pass, mismatch_mask, cap_in, cap_out_1, cap_out_2, pass_count, fail_count} !== 41'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b pass=%b mask=%b caps=%h/%h/%h counts=%0d/%0d required all zero",
               busy, done, pass, mismatch_mask, cap_in, cap_out_1, cap_out_2, pass_count, fail_count);
    end
  endtask

  task automatic test_pass;
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    pulse_start(10'd5, 6'b111010, 6'b110010, 6'b100010);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL pass_busy_t1: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    set_sigs(6'b010101, 6'b001100, 6'b111111);
    tick(3);
    set_sigs(6'b111010, 6'b110010, 6'b100010);
    tick(1);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL pass_busy_t5: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    tick(1);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || mismatch_mask !== 4'b0000 || busy !== 1'b0 ||
        pass_count !== 8'd1 || fail_count !== 8'd0) begin
      errors++;
      $display("FAIL pass_result: done=%b pass=%b mask=%b busy=%b pc=%0d fc=%0d required 1 1 0000 0 1 0",
               done, pass, mismatch_mask, busy, pass_count, fail_count);
    end
    tick(1);
    vectors++;
    if (done !== 1'b0 || pass !== 1'b1 || cap_out_2 !== 6'b100010) begin
      errors++;
      $display("FAIL pass_hold: done=%b pass=%b cap_out_2=%b required 0 1 100010", done, pass, cap_out_2);
    end
  endtask

  task automatic test_mismatch;
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    pulse_start(10'd5, 6'b111010, 6'b110010, 6'b100010);
    tick(3);
    set_sigs(6'b111010, 6'b110011, 6'b100010);
    tick(1);
    tick(1);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b0 || mismatch_mask !== 4'b0010 || cap_out_1 !== 6'b110011 ||
        cap_in !== 6'b111010 || fail_count !== 8'd1 || pass_count !== 8'd1) begin
      errors++;
      $display("FAIL out1_mismatch: done=%b pass=%b mask=%b cap1=%b cap_in=%b pc=%0d fc=%0d required 1 0 0010 110011 111010 1 1",
               done, pass, mismatch_mask, cap_out_1, cap_in, pass_count, fail_count);
    end
  endtask

  task automatic test_seed;
    set_sigs(6'b000010, 6'b000001, 6'b000001);
    pulse_start(10'd5, 6'b111010, 6'b110010, 6'b100010);
    vectors++;
    if (pass !== 1'b0 || mismatch_mask !== 4'b0000) begin
      errors++; $display("FAIL start_clears: pass=%b mask=%b required 0 0000", pass, mismatch_mask);
    end
    tick(3);
    set_sigs(6'b111010, 6'b110010, 6'b100010);
    tick(2);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b0 || mismatch_mask !== 4'b1000 || fail_count !== 8'd2) begin
      errors++;
      $display("FAIL seed_error: done=%b pass=%b mask=%b fc=%0d required 1 0 1000 2", done, pass, mismatch_mask, fail_count);
    end
    tick(1);
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    pulse_start(10'd0, 6'b000001, 6'b000001, 6'b000001);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || mismatch_mask !== 4'b0000 || pass_count !== 8'd2) begin
      errors++;
      $display("FAIL zero_window: done=%b pass=%b busy=%b mask=%b pc=%0d required 1 1 0 0000 2",
               done, pass, busy, mismatch_mask, pass_count);
    end
    tick(1);
  endtask

  task automatic test_back_to_back;
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    pulse_start(10'd5, 6'b111010, 6'b110010, 6'b100010);
    tick(1);
    pulse_start(10'd1, 6'b000000, 6'b000000, 6'b000000);
    tick(1);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ignore_start_t4: done=%b busy=%b required 0 1", done, busy);
    end
    tick(1);
    set_sigs(6'b111010, 6'b110010, 6'b100010);
    tick(1);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || pass_count !== 8'd3) begin
      errors++; $display("FAIL ignore_start_t6: done=%b pass=%b pc=%0d required 1 1 3", done, pass, pass_count);
    end
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    pulse_start(10'd5, 6'b101010, 6'b010101, 6'b110011);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || pass !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: done=%b busy=%b pass=%b required 0 1 0", done, busy, pass);
    end
    tick(3);
    set_sigs(6'b101010, 6'b010101, 6'b110011);
    tick(1);
    vectors++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL b2b_early: done=%b required 0", done);
    end
    tick(1);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || pass_count !== 8'd4 || cap_out_2 !== 6'b110011) begin
      errors++;
      $display("FAIL b2b_result: done=%b pass=%b pc=%0d cap2=%b required 1 1 4 110011", done, pass, pass_count, cap_out_2);
    end
    tick(1);
  endtask

  task automatic test_reset_midrun;
    int seen_done;
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    pulse_start(10'd5, 6'b000001, 6'b000001, 6'b000001);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || pass_count !== 8'd0 || fail_count !== 8'd0 || mismatch_mask !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b pc=%0d fc=%0d mask=%b required 0 0 0 0 0000",
               busy, done, pass_count, fail_count, mismatch_mask);
    end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done != 0) begin
      errors++; $display("FAIL aborted_run: activity_cycles=%0d required 0", seen_done);
    end
    pulse_start(10'd2, 6'b000111, 6'b000001, 6'b000001);
    set_sigs(6'b000111, 6'b000001, 6'b000001);
    tick(2);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || pass_count !== 8'd1 || fail_count !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_run: done=%b pass=%b pc=%0d fc=%0d required 1 1 1 0", done, pass, pass_count, fail_count);
    end
    tick(1);
  endtask

  task automatic test_saturation;
    rst2 = 1'b0;
    tick(1);
    set_sigs(6'b000001, 6'b000001, 6'b000001);
    start = 1'b1; window_len = 10'd0;
    exp_in = 6'b111111; exp_out_1 = 6'b000001; exp_out_2 = 6'b000001;
    tick(5);
    start = 1'b0;
    tick(1);
    vectors++;
    if (fail_count2 !== 2'd3 || pass_count2 !== 2'd0 || mask2 !== 4'b0001) begin
      errors++;
      $display("FAIL saturate: fc=%0d pc=%0d mask=%b required 3 0 0001", fail_count2, pass_count2, mask2);
    end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_mismatch;
    test_seed;
    test_back_to_back;
    test_reset_midrun;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
